tdm_demux4: RTL and testbench

TDM_DEMUX4 -- requirements
Module: tdm_demux4

---
 rtl/tdm_pkg.sv | 17 +
 rtl/tdm_slot_cnt.sv | 31 +++
 rtl/tdm_demux4.sv | 137 +++++++++++++
 tb/tb_tdm_demux4.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM demultiplexer.
//   NUM_SLOTS   : slots per frame
//   slot_t      : slot index type
//   tdm_state_t : framing FSM states
package tdm_pkg;

  localparam int unsigned NUM_SLOTS = 4;

  typedef logic [1:0] slot_t;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } tdm_state_t;

endpackage

// File: rtl/tdm_slot_cnt.sv
// Modulo-4 slot counter for the TDM demultiplexer.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_en       : advance one slot (wraps 3 -> 0)
//   i_load     : synchronous load to slot 1 (the current beat was slot 0);
//                has priority over i_en
//   o_slot     : index of the next expected slot (registered)
module tdm_slot_cnt
  import tdm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_load,
  output logic [1:0] o_slot
);

  slot_t r_slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
    end else if (i_load) begin
      r_slot <= slot_t'(1);
    end else if (i_en) begin
      r_slot <= r_slot + slot_t'(1);
    end
  end

  assign o_slot = r_slot;

endmodule

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer with sync hunting and frame lock detection.
//   clk, rst_n        : clock, asynchronous active-low reset
//   din, din_valid    : serial data beat, one slot per valid beat
//   sync              : marks the valid beat as slot 0
//   z0..z3            : slots 0..3 of the last completed frame
//   frame_valid       : one-cycle pulse when z0..z3 update
//   slot              : index of the next expected slot
//   locked            : high while in LOCKED
//   sync_err          : one-cycle pulse when sync lands on slot 1..3
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_valid,
  input  logic       sync,
  output logic       z0,
  output logic       z1,
  output logic       z2,
  output logic       z3,
  output logic       frame_valid,
  output logic [1:0] slot,
  output logic       locked,
  output logic       sync_err
);

  localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);

  tdm_state_t  r_state, w_state_nxt;
  logic [3:0]  r_good_cnt, w_good_nxt;
  logic [4:0]  w_good_inc;
  // Slot 3 is never held: it goes straight from din into z3.
  logic [2:0]  r_shadow;
  logic [3:0]  r_z;
  logic        r_frame_valid, r_sync_err, r_locked;
  logic [1:0]  w_slot;
  logic        w_hunt, w_start, w_resync, w_advance, w_frame;

  assign w_hunt    = (r_state == HUNT);
  assign w_start   = din_valid & sync & w_hunt;
  // Sync off slot 0 restarts the frame; sync on slot 0 is just a normal beat.
  assign w_resync  = din_valid & sync & ~w_hunt & (w_slot != '0);
  assign w_advance = din_valid & ~w_hunt & ~w_resync;
  assign w_frame   = w_advance & (w_slot == LAST_SLOT);
  assign w_good_inc = {1'b0, r_good_cnt} + 5'd1;

  tdm_slot_cnt u_slot_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_advance),
    .i_load (w_start | w_resync),
    .o_slot (w_slot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HUNT;
      r_good_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    case (r_state)
      HUNT: begin
        if (w_start) begin
          w_state_nxt = ACQUIRE;
          w_good_nxt  = '0;
        end
      end
      ACQUIRE: begin
        if (w_resync) begin
          w_good_nxt = '0;
        end else if (w_frame) begin
          w_good_nxt = w_good_inc[3:0];
          if (w_good_inc >= 5'(LOCK_FRAMES)) begin
            w_state_nxt = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (w_resync) begin
          w_state_nxt = ACQUIRE;
          w_good_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = HUNT;
        w_good_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow      <= '0;
      r_z           <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      r_frame_valid <= w_frame;
      r_sync_err    <= w_resync;
      r_locked      <= (w_state_nxt == LOCKED);
      if (w_start || w_resync) begin
        r_shadow[0] <= din;
      end else if (w_advance) begin
        case (w_slot)
          2'd0:    r_shadow[0] <= din;
          2'd1:    r_shadow[1] <= din;
          2'd2:    r_shadow[2] <= din;
          default: ;
        endcase
      end
      if (w_frame) begin
        r_z <= {din, r_shadow[2], r_shadow[1], r_shadow[0]};
      end
    end
  end

  assign z0          = r_z[0];
  assign z1          = r_z[1];
  assign z2          = r_z[2];
  assign z3          = r_z[3];
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;
  assign locked      = r_locked;
  assign slot        = w_slot;

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: the driver runs a frame-level model and
// queues expected frames / sync errors; a monitor pops them when the DUT
// pulses frame_valid or sync_err.
module tb_tdm_demux4;

  localparam int LOCK_FRAMES = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0, din_valid = 1'b0, sync = 1'b0;
  logic       z0, z1, z2, z3, frame_valid, locked, sync_err;
  logic [1:0] slot;

  tdm_demux4 #(.LOCK_FRAMES(LOCK_FRAMES)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
    .z0(z0), .z1(z1), .z2(z2), .z3(z3), .frame_valid(frame_valid),
    .slot(slot), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int       due;
    logic [3:0] z;   // {slot0, slot1, slot2, slot3}
    bit       lk;
  } exp_t;

  exp_t exp_frame[$];
  exp_t exp_err[$];

  // Frame-level reference model
  bit         m_hunt = 1'b1;
  bit         m_bits[$];
  int         m_good = 0;
  bit         m_locked = 1'b0;
  logic [3:0] m_z = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock with the given inputs; the model decides what the DUT must do.
  task automatic beat(input bit v, input bit s, input bit d);
    exp_t e;
    @(negedge clk);
    din_valid = v; sync = s; din = d;
    if (v) begin
      if (m_hunt) begin
        if (s) begin
          m_hunt = 1'b0;
          m_bits = {d};
          m_good = 0;
        end
      end else if (s && m_bits.size() != 0) begin
        m_bits   = {d};
        m_good   = 0;
        m_locked = 1'b0;
        e.due = cyc + 1; e.z = m_z; e.lk = 1'b0;
        exp_err.push_back(e);
      end else begin
        m_bits.push_back(d);
        if (m_bits.size() == 4) begin
          m_z = {m_bits[0], m_bits[1], m_bits[2], m_bits[3]};
          m_bits.delete();
          if (!m_locked) begin
            m_good++;
            if (m_good >= LOCK_FRAMES) m_locked = 1'b1;
          end
          e.due = cyc + 1; e.z = m_z; e.lk = m_locked;
          exp_frame.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    check("slot", 32'(slot), m_hunt ? 32'd0 : 32'(m_bits.size()));
    check("locked", 32'(locked), 32'(m_locked));
  endtask

  task automatic frame4(input logic [3:0] b);  // b = {d0,d1,d2,d3}
    beat(1'b1, 1'b1, b[3]);
    beat(1'b1, 1'b0, b[2]);
    beat(1'b1, 1'b0, b[1]);
    beat(1'b1, 1'b0, b[0]);
  endtask

  task automatic model_reset();
    m_hunt = 1'b1; m_bits.delete(); m_good = 0; m_locked = 1'b0; m_z = '0;
    exp_frame.delete(); exp_err.delete();
  endtask

  // Asynchronous pulse between clock edges.
  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_outs", 32'({z0, z1, z2, z3, frame_valid, slot, locked, sync_err}), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (frame_valid && sync_err) check("fv_and_err", 32'd1, 32'd0);
      if (frame_valid) begin
        if (exp_frame.size() == 0) begin
          check("frame_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_frame.pop_front();
          check("frame_cycle", 32'(cyc), 32'(e.due));
          check("frame_z", 32'({z0, z1, z2, z3}), 32'(e.z));
          check("frame_locked", 32'(locked), 32'(e.lk));
        end
      end
      if (sync_err) begin
        if (exp_err.size() == 0) begin
          check("err_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_err.pop_front();
          check("err_cycle", 32'(cyc), 32'(e.due));
          check("err_z_held", 32'({z0, z1, z2, z3}), 32'(e.z));
          check("err_locked", 32'(locked), 32'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit s;
    repeat (2) @(negedge clk);
    check("reset_outs", 32'({z0, z1, z2, z3, frame_valid, slot, locked, sync_err}), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Beats without sync stay in HUNT
    for (int i = 0; i < 10; i++) beat(1'b1, 1'b0, 1'($urandom));

    // Frame 1101 in slot order d0..d3; not yet locked
    frame4(4'b1101);
    beat(1'b0, 1'b0, 1'b0);

    // Two frames with idle gaps (sync/din toggling on gaps must be ignored)
    async_reset();
    beat(1'b1, 1'b1, 1'b0);
    beat(1'b0, 1'b1, 1'b1);
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b1, 1'b1);
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b0, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b1);
    check("locked_after_two", 32'(locked), 32'd1);

    // Locked: a further frame, then sync at slot 2
    frame4(4'b0110);
    beat(1'b1, 1'b1, 1'b1);
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);

    // Reset mid-frame with beats streaming, then unsynced data is ignored
    beat(1'b1, 1'b1, 1'b1);
    beat(1'b1, 1'b0, 1'b1);
    async_reset();
    for (int i = 0; i < 6; i++) beat(1'b1, 1'b0, 1'($urandom));

    // Random traffic
    for (int i = 0; i < 1000; i++) begin
      if (m_hunt || m_bits.size() == 0) s = ($urandom_range(0, 4) != 0);
      else                              s = ($urandom_range(0, 29) == 0);
      beat(($urandom_range(0, 3) != 0), s, 1'($urandom));
    end
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);

    check("frames_left", 32'(exp_frame.size()), 32'd0);
    check("errs_left", 32'(exp_err.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
